// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a single shared memory port stalled by mem_ready.
module mips_multicycle_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q, state_d;
  logic       pcwrite;
  logic       branch;
  logic       funct_ok;
  logic [2:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        // PC/IR only update once the fetch completes, and never while held in reset
        if (mem_ready && !rst) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_EXEC;
            end else begin
              state_d    = S_FETCH;
              illegal_op = ILLEGAL_TRAP;
            end
          end
          default: begin
            state_d    = S_FETCH;
            illegal_op = ILLEGAL_TRAP;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        branch     = 1'b1;
        pcsrc      = 2'b01;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: per-scenario tasks compare every cycle
// against an instruction-level model of state sequences and control outputs.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal_op;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'b100000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       regwrite, regdst, memtoreg, illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  int   q_st[$];
  logic q_rdy[$];
  logic q_z[$];

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
    .iord(iord), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  function automatic out_t observed();
    observed = {state, mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
                alusrcb, alucontrol, regwrite, regdst, memtoreg, illegal_op};
  endfunction

  function automatic logic funct_legal(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic instr_legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000) return funct_legal(f);
    return o inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Control word each named step of an instruction must present.
  function automatic out_t expect_out(input int st, input logic rdy, input logic [5:0] o,
                                      input logic [5:0] f, input logic z, input logic r);
    out_t e;
    e = '0;
    e.st = st[3:0];
    e.alucontrol = 3'b010;
    case (st)
      0:  begin e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = rdy & ~r; e.pcen = rdy & ~r; end
      1:  begin e.alusrcb = 2'b11; e.illegal_op = ~instr_legal(o, f); end
      2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3:  begin e.mem_req = 1; e.iord = 1; end
      4:  begin e.regwrite = 1; e.memtoreg = 1; end
      5:  begin e.mem_req = 1; e.memwrite = 1; e.iord = 1; end
      6:  begin e.alusrca = 1; e.alucontrol = funct_to_alu(f); end
      7:  begin e.regwrite = 1; e.regdst = 1; end
      8:  begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      10: e.regwrite = 1;
      11: begin e.pcen = 1; e.pcsrc = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  // zm: 0/1 forces the zero flag, 2 randomises it per cycle
  task automatic push(input int st, input logic rdy, input int zm);
    q_st.push_back(st);
    q_rdy.push_back(rdy);
    q_z.push_back(zm == 2 ? 1'($urandom_range(0, 1)) : 1'(zm));
  endtask

  // Expected step list for one instruction: fw fetch stalls, mw data stalls.
  task automatic build_seq(input logic [5:0] o, input logic [5:0] f,
                           input int fw, input int mw, input int zm);
    q_st.delete(); q_rdy.delete(); q_z.delete();
    for (int i = 0; i < fw; i++) push(0, 1'b0, zm);
    push(0, 1'b1, zm);
    push(1, 1'($urandom_range(0, 1)), zm);
    if (!instr_legal(o, f)) return;
    case (o)
      6'b100011: begin
        push(2, 1'($urandom_range(0, 1)), zm);
        for (int i = 0; i < mw; i++) push(3, 1'b0, zm);
        push(3, 1'b1, zm);
        push(4, 1'($urandom_range(0, 1)), zm);
      end
      6'b101011: begin
        push(2, 1'($urandom_range(0, 1)), zm);
        for (int i = 0; i < mw; i++) push(5, 1'b0, zm);
        push(5, 1'b1, zm);
      end
      6'b000100: push(8, 1'($urandom_range(0, 1)), zm);
      6'b001000: begin push(9, 1'b1, zm); push(10, 1'b0, zm); end
      6'b000010: push(11, 1'($urandom_range(0, 1)), zm);
      default:   begin push(6, 1'b0, zm); push(7, 1'b1, zm); end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; op = 6'b000000; funct = 6'b100000;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (state !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_state got %0d expected 0", state); end
    n_checks++;
    if (pcen !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pcen got %b expected 0", pcen); end
    n_checks++;
    if (regwrite !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_regwrite got %b expected 0", regwrite); end
    n_checks++;
    if (illegal_op !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_illegal got %b expected 0", illegal_op); end
  endtask

  task automatic test_rtype();
    out_t e;
    build_seq(6'b000000, 6'b100000, 0, 0, 2);
    for (int i = 0; i < q_st.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin op = 6'b000000; funct = 6'b100000; end
      rst = 1'b0; mem_ready = q_rdy[i]; zero = q_z[i]; #1;
      e = expect_out(q_st[i], q_rdy[i], op, funct, q_z[i], 1'b0);
      n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("[TB] FAIL rtype step %0d got %h expected %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_lw_wait();
    out_t e;
    build_seq(6'b100011, 6'b000000, 0, 3, 2);
    for (int i = 0; i < q_st.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin op = 6'b100011; funct = 6'b000000; end
      mem_ready = q_rdy[i]; zero = q_z[i]; #1;
      e = expect_out(q_st[i], q_rdy[i], op, funct, q_z[i], 1'b0);
      n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("[TB] FAIL lw_wait step %0d got %h expected %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_beq();
    out_t e;
    for (int zv = 1; zv >= 0; zv--) begin
      build_seq(6'b000100, 6'b010101, 0, 0, zv);
      for (int i = 0; i < q_st.size(); i++) begin
        @(negedge clk);
        if (i == 0) begin op = 6'b000100; funct = 6'b010101; end
        mem_ready = q_rdy[i]; zero = q_z[i]; #1;
        e = expect_out(q_st[i], q_rdy[i], op, funct, q_z[i], 1'b0);
        n_checks++;
        if (observed() !== e) begin
          n_fail++; $display("[TB] FAIL beq_z%0d step %0d got %h expected %h", zv, i, observed(), e);
        end
      end
    end
  endtask

  task automatic test_jump_addi();
    out_t e;
    logic [5:0] ops [2];
    ops[0] = 6'b000010; ops[1] = 6'b001000;
    for (int k = 0; k < 2; k++) begin
      build_seq(ops[k], 6'b111000, 1, 0, 2);
      for (int i = 0; i < q_st.size(); i++) begin
        @(negedge clk);
        if (i == 0) begin op = ops[k]; funct = 6'b111000; end
        mem_ready = q_rdy[i]; zero = q_z[i]; #1;
        e = expect_out(q_st[i], q_rdy[i], op, funct, q_z[i], 1'b0);
        n_checks++;
        if (observed() !== e) begin
          n_fail++; $display("[TB] FAIL jump_addi op%0d step %0d got %h expected %h", k, i, observed(), e);
        end
      end
    end
  endtask

  task automatic test_illegal();
    out_t e;
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    ops[0] = 6'b111111; fns[0] = 6'b100000;
    ops[1] = 6'b000000; fns[1] = 6'b000111;
    ops[2] = 6'b000000; fns[2] = 6'b101010;
    for (int k = 0; k < 3; k++) begin
      build_seq(ops[k], fns[k], 0, 0, 2);
      for (int i = 0; i < q_st.size(); i++) begin
        @(negedge clk);
        if (i == 0) begin op = ops[k]; funct = fns[k]; end
        mem_ready = q_rdy[i]; zero = q_z[i]; #1;
        e = expect_out(q_st[i], q_rdy[i], op, funct, q_z[i], 1'b0);
        n_checks++;
        if (observed() !== e) begin
          n_fail++; $display("[TB] FAIL illegal%0d step %0d got %h expected %h", k, i, observed(), e);
        end
      end
    end
  endtask

  task automatic test_reset_midwrite();
    out_t e;
    build_seq(6'b101011, 6'b000000, 0, 5, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin op = 6'b101011; funct = 6'b000000; end
      mem_ready = q_rdy[i]; zero = q_z[i]; #1;
      e = expect_out(q_st[i], q_rdy[i], op, funct, q_z[i], 1'b0);
      n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("[TB] FAIL sw_pre_reset step %0d got %h expected %h", i, observed(), e);
      end
    end
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    n_checks++;
    if (state !== 4'd0) begin n_fail++; $display("[TB] FAIL sw_reset_state got %0d expected 0", state); end
    n_checks++;
    if (memwrite !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_reset_memwrite got %b expected 0", memwrite); end
  endtask

  task automatic test_back_to_back();
    out_t e;
    logic [5:0] o, f;
    int pick;
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 9);
      f = 6'($urandom_range(0, 63));
      case (pick)
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000100;
        3: o = 6'b001000;
        4: o = 6'b000010;
        5: o = 6'($urandom_range(0, 63));
        default: begin
          o = 6'b000000;
          case ($urandom_range(0, 5))
            0: f = 6'b100000;
            1: f = 6'b100010;
            2: f = 6'b100100;
            3: f = 6'b100101;
            4: f = 6'b101010;
            default: ;
          endcase
        end
      endcase
      build_seq(o, f, $urandom_range(0, 2), $urandom_range(0, 2), 2);
      for (int i = 0; i < q_st.size(); i++) begin
        @(negedge clk);
        if (i == 0) begin op = o; funct = f; end
        mem_ready = q_rdy[i]; zero = q_z[i]; #1;
        e = expect_out(q_st[i], q_rdy[i], op, funct, q_z[i], 1'b0);
        n_checks++;
        if (observed() !== e) begin
          n_fail++;
          $display("[TB] FAIL random instr %0d op %b funct %b step %0d got %h expected %h",
                   n, o, f, i, observed(), e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_jump_addi();
    test_illegal();
    test_reset_midwrite();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Control FSM that sequences the MIPS datapath over several cycles per instruction, replacing the single-cycle combinational decoder.
- A single shared memory port serves instruction fetch and data access, stalled by a ready handshake.
- Sits beside the datapath. Takes opcode/funct from the latched instruction register and the ALU zero flag. Drives all datapath mux selects, register/memory write enables, PC enable and the ALU operation.

Parameters:
- ILLEGAL_TRAP, 1, 1: unsupported opcode/funct pulses illegal_op and returns to FETCH; 0: silently treated as NOP.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed current read/write this cycle
- mem_req  out  1  memory access request (fetch, lw read, sw write)
- memwrite  out  1  write strobe qualifying mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  load instruction register
- pcen  out  1  PC load enable = pcwrite OR (branch AND zero)
- pcsrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- alusrca  out  1  0 = PC, 1 = rdata1
- alusrcb  out  2  00 rdata2, 01 const 4, 10 imm_extend, 11 imm_extend<<2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- regwrite  out  1  register file write enable
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = MDR
- illegal_op  out  1  one-cycle pulse on unsupported instruction
- state  out  4  current state encoding, for debug/verification

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and go to FETCH.
- Reset: state=FETCH. All outputs are Moore/combinational from state, so on the cycle after rst the FETCH outputs apply. illegal_op=0.
- rst asserted mid-instruction forces FETCH on the next edge regardless of mem_ready. Any partial write is abandoned.
- Default for every output not listed for a state: 0 (alucontrol=010).
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - irwrite and pcwrite are asserted only when mem_ready=1, then go to DECODE.
  - With mem_ready=0, stay in FETCH with no PC/IR update.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 with supported funct → EXEC
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - else illegal → FETCH, with illegal_op=1 in this cycle if ILLEGAL_TRAP=1
- MEMADR: alusrca=1, alusrcb=10, add. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: mem_req=1, iord=1. Wait until mem_ready, then → MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1 → FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Wait until mem_ready, then → FETCH.
- EXEC: alusrca=1, alusrcb=00. alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt → ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0 → FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01, so pcen=zero → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add → ADDIWB. ADDIWB: regwrite=1, regdst=0, memtoreg=0 → FETCH.
- JUMP: pcwrite=1, pcsrc=10 → FETCH.
- Cycles per instruction with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle on mem_ready adds exactly 1 cycle.
- Unsupported funct under op=000000 is illegal, handled identically to an unsupported opcode.
- regwrite and memwrite are never asserted in the same cycle. pcen is never asserted outside FETCH, BRANCH and JUMP.

Test Plan:
- Reset with rst=1 for 2 cycles, mem_ready=1, op=000000, funct=100000 → state=0, pcen=0, regwrite=0; then state sequence 0,1,6,7,0 with alucontrol=010 in EXEC and regwrite=1, regdst=1 in ALUWB.
- lw (op=100011) with mem_ready low for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0; mem_req=1 and iord=1 throughout MEMRD; memtoreg=1 and regwrite=1 only in MEMWB.
- beq (op=000100) with zero=1, then zero=0 → BRANCH has alucontrol=110, pcsrc=01; pcen=1 and 0 respectively; 3 cycles each.
- j (op=000010) then addi (op=001000) → JUMP has pcen=1, pcsrc=10; ADDIEX has alusrcb=10; ADDIWB has regdst=0, regwrite=1.
- op=111111 with ILLEGAL_TRAP=1 → illegal_op=1 for exactly one cycle in DECODE, next state=FETCH, no regwrite/memwrite; op=000000 with funct=000111 gives the same result.
- sw (op=101011) with rst pulsed during MEMWR while mem_ready=0 → next state=FETCH, memwrite=0 the cycle after reset.
